// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and pointer-width helper
package fifo_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;
    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/fifo_method1_mem.sv
// fifo_method1_mem: register array with sync write and registered read port
module fifo_method1_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_method1.sv
// fifo_method1: single-clock FIFO with binary pointers and occupancy counter
module fifo_method1 import fifo_pkg::*; #(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr, do_rd;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr & ~do_rd) count <= count + CW'(1);
            else if (do_rd & ~do_wr) count <= count - CW'(1);
        end
    end
    fifo_method1_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (do_rd),
        .raddr (rd_ptr),
        .rdata (data_out)
    );
endmodule

// File: tb/tb_fifo_method1.sv
// tb_fifo_method1: directed stimulus checked against a queue model and literals
module tb_fifo_method1;
    logic       clk = 0;
    logic       rst = 0;
    logic       wr_en = 0, rd_en = 0;
    logic [7:0] data_in = 0;
    logic [7:0] data_out;
    logic       full, empty;
    int         checks = 0, failures = 0;
    bit         chk_en = 0;
    logic [7:0] q[$];
    logic [7:0] exp_dout = 0;

    fifo_method1 dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Model: queue of stored words, read pops into the expected output register
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            exp_dout = 0;
        end else begin
            automatic bit w = wr_en && q.size() < 8;
            automatic bit r = rd_en && q.size() > 0;
            if (r) exp_dout = q.pop_front();
            if (w) q.push_back(data_in);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_empty", int'(empty), int'(q.size() == 0));
            chk("model_full", int'(full), int'(q.size() == 8));
            chk("model_dout", int'(data_out), int'(exp_dout));
        end
    end

    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_dout", int'(data_out), 0);
        rst = 1;
        chk_en = 1;
        for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i));
        chk("fill_full", int'(full), 1);
        chk("fill_empty", int'(empty), 0);
        cycle(1, 0, 8'd9);
        chk("over_full", int'(full), 1);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 0);
            chk("drain_dout", int'(data_out), i);
        end
        chk("drain_empty", int'(empty), 1);
        cycle(0, 1, 0);
        chk("under_dout", int'(data_out), 8);
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hA0 + i));
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0);
            chk("pre_wrap_dout", int'(data_out), 8'hA0 + i);
        end
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h10 + i));
        chk("wrap_full", int'(full), 1);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0);
            chk("wrap_dout", int'(data_out), 8'h10 + i);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 8'(8'h40 + i));
            chk("sim_dout", int'(data_out), (i < 4) ? 8'h30 + i : 8'h40);
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        chk("sim_cnt_nonempty", int'(empty), 0);
        cycle(0, 1, 0);
        chk("sim_cnt_empty", int'(empty), 1);
        chk("sim_last", int'(data_out), 8'h44);
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h50 + i));
        cycle(1, 1, 8'hEE);
        chk("full_both_full", int'(full), 0);
        chk("full_both_dout", int'(data_out), 8'h50);
        for (int i = 1; i < 8; i++) begin
            cycle(0, 1, 0);
            chk("full_both_drain", int'(data_out), 8'h50 + i);
        end
        chk("full_both_empty", int'(empty), 1);
        cycle(1, 1, 8'h77);
        chk("empty_both_empty", int'(empty), 0);
        chk("empty_both_dout", int'(data_out), 8'h57);
        cycle(0, 1, 0);
        chk("empty_both_read", int'(data_out), 8'h77);
        chk("empty_both_after", int'(empty), 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'(8'hC0 + i));
        #1 rst = 0;
        #1;
        chk("async_empty", int'(empty), 1);
        chk("async_full", int'(full), 0);
        chk("async_dout", int'(data_out), 0);
        @(negedge clk);
        rst = 1;
        cycle(0, 1, 0);
        chk("post_rst_dout", int'(data_out), 0);
        chk("post_rst_empty", int'(empty), 1);
        cycle(1, 0, 8'h99);
        cycle(0, 1, 0);
        chk("post_rst_read", int'(data_out), 8'h99);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
